// File: rtl/ul4_acc.sv
// ul4_acc: FIFO-buffered 4-bit logic unit with accumulator feedback and valid/ready result port
module ul4_acc #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_ld,
  input  logic [1:0]               in_op,
  input  logic [3:0]               in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_res,
  output logic                     out_zero,
  output logic [3:0]               acc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [6:0]    head;
  logic [3:0]    r;
  logic          push, exe;
  assign in_ready = (count != CW'(DEPTH)) && !reset;
  assign push     = in_valid && in_ready;
  assign exe      = (count != '0) && (!out_valid || out_ready);
  assign head     = mem[rp];
  // result of the head command against the current accumulator
  always_comb
    r = head[6]            ? head[3:0] :
        head[5:4] == 2'b00 ? acc & head[3:0] :
        head[5:4] == 2'b01 ? acc | head[3:0] :
        head[5:4] == 2'b10 ? acc ^ head[3:0] : ~acc;
  // command storage, written at the tail on accept
  always_ff @(posedge clk)
    if (push) mem[wp] <= {in_ld, in_op, in_b};
  // pointers, occupancy, accumulator and output register
  always_ff @(posedge clk)
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      acc       <= '0;
      out_res   <= '0;
      out_zero  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (exe) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(exe);
      if (exe) begin
        acc       <= r;
        out_res   <= r;
        out_zero  <= (r == 4'b0000);
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule
